// File: rtl/pooling_sequencer.sv
// Sequencer for PoolingUnit: loads one lane vector, steps the tree-reduction control
// words through log2(window) stages, waits out the unit latency and hands the result on.
module pooling_sequencer #(
    parameter int depth = 4,
    parameter int W     = 4,
    parameter int CW    = 8,
    parameter int LAT   = 1
) (
    input  logic                    CLK,
    input  logic                    RSTN,
    input  logic                    start,
    input  logic [2:0]              cfg_k,
    input  logic [CW-1:0]           cfg_count,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    doPooling,
    output logic [(4<<depth)-1:0]   control,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    done
);

    localparam int D  = 1 << depth;
    localparam int LW = $clog2(LAT + 1) + 1;
    // The stage field of a control word is 3 bits, so at most 7 reduction stages exist.
    localparam bit PARAMS_OK = (W >= 1) && (depth >= 1) && (depth <= 7) && (CW >= 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_REDUCE = 3'd2,
        S_WAIT   = 3'd3,
        S_OUT    = 3'd4,
        S_FIN    = 3'd5
    } state_t;

    localparam state_t S_AFTER_RED = (LAT == 0) ? S_OUT : S_WAIT;

    state_t          state_q, state_d;
    logic [2:0]      stage_q, stage_d;
    logic [LW-1:0]   lat_q, lat_d;
    logic [CW-1:0]   vec_q, vec_d;
    logic [2:0]      kq_q, kq_d;
    logic [CW-1:0]   nq_q, nq_d;

    logic            in_ready_q;
    logic            do_pool_q;
    logic [4*D-1:0]  control_q;
    logic            out_valid_q;
    logic            busy_q;
    logic            done_q;

    // Lanes whose index is a multiple of 2^(s+1) combine with their partner at stage s.
    function automatic logic [4*D-1:0] reduce_ctrl(input logic [2:0] s);
        logic [4*D-1:0] ctl;
        int             span_mask;
        ctl       = {(4*D){1'b0}};
        span_mask = (32'sd2 <<< s) - 32'sd1;
        for (int j = 0; j < D; j++) begin
            if ((j & span_mask) == 32'sd0) begin
                ctl[4*j +: 4] = {1'b1, s};
            end else begin
                ctl[4*j +: 4] = 4'b0000;
            end
        end
        return ctl;
    endfunction

    // Sequencer state and job counters.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= S_IDLE;
            stage_q <= 3'd0;
            lat_q   <= {LW{1'b0}};
            vec_q   <= {CW{1'b0}};
            kq_q    <= 3'd0;
            nq_q    <= {CW{1'b0}};
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            lat_q   <= lat_d;
            vec_q   <= vec_d;
            kq_q    <= kq_d;
            nq_q    <= nq_d;
        end
    end

    // Next-state logic; handshakes use the registered ready/valid, which mirror LOAD/OUT.
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        lat_d   = lat_q;
        vec_d   = vec_q;
        kq_d    = kq_q;
        nq_d    = nq_q;
        case (state_q)
            S_IDLE: begin
                if (start && PARAMS_OK) begin
                    kq_d    = (cfg_k > 3'(depth)) ? 3'(depth) : cfg_k;
                    nq_d    = cfg_count;
                    vec_d   = {CW{1'b0}};
                    state_d = (cfg_count == {CW{1'b0}}) ? S_FIN : S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (in_valid && in_ready_q) begin
                    stage_d = 3'd0;
                    lat_d   = {LW{1'b0}};
                    state_d = (kq_q == 3'd0) ? S_AFTER_RED : S_REDUCE;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_REDUCE: begin
                if (stage_q == (kq_q - 3'd1)) begin
                    state_d = S_AFTER_RED;
                end else begin
                    stage_d = stage_q + 3'd1;
                end
            end
            S_WAIT: begin
                if ((lat_q + LW'(1)) == LW'(LAT)) begin
                    state_d = S_OUT;
                end else begin
                    lat_d = lat_q + LW'(1);
                end
            end
            S_OUT: begin
                if (out_ready && out_valid_q) begin
                    vec_d   = vec_q + CW'(1);
                    state_d = ((vec_q + CW'(1)) == nq_q) ? S_FIN : S_LOAD;
                end else begin
                    state_d = S_OUT;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so each output is a clean flop.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            in_ready_q  <= 1'b0;
            do_pool_q   <= 1'b0;
            control_q   <= {(4*D){1'b0}};
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            in_ready_q  <= (state_d == S_LOAD);
            do_pool_q   <= (state_d == S_REDUCE) || (state_d == S_WAIT);
            control_q   <= (state_d == S_REDUCE) ? reduce_ctrl(stage_d) : {(4*D){1'b0}};
            out_valid_q <= (state_d == S_OUT);
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_FIN);
        end
    end

    assign in_ready  = in_ready_q;
    assign doPooling = do_pool_q;
    assign control   = control_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_pooling_sequencer.sv
// Bench for pooling_sequencer: a cycle-timeline model checked every cycle, directed
// scenarios with literal expectations, then randomized handshakes and starts.
module tb_pooling_sequencer;

    localparam int DEPTH = 4;
    localparam int D     = 1 << DEPTH;
    localparam int CW    = 8;
    localparam int LAT   = 1;

    logic            CLK = 1'b0;
    logic            RSTN = 1'b0;
    logic            start = 1'b0;
    logic [2:0]      cfg_k = 3'd0;
    logic [CW-1:0]   cfg_count = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic            doPooling;
    logic [4*D-1:0]  control;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic            busy;
    logic            done;

    int n_chk = 0;
    int n_fail = 0;
    int done_cnt = 0;
    bit chk_en = 1'b0;

    pooling_sequencer #(.depth(DEPTH), .W(4), .CW(CW), .LAT(LAT)) dut (
        .CLK(CLK), .RSTN(RSTN), .start(start), .cfg_k(cfg_k), .cfg_count(cfg_count),
        .in_valid(in_valid), .in_ready(in_ready), .doPooling(doPooling), .control(control),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h time=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: a job is a timeline counted in cycles since the input vector was accepted.
    bit  m_active = 1'b0;
    bit  m_fin = 1'b0;
    int  m_phase = 0;
    int  m_k = 0;
    int  m_n = 0;
    int  m_cnt = 0;

    logic            e_in_ready, e_dop, e_ov, e_busy, e_done;
    logic [4*D-1:0]  e_ctrl;

    always_comb begin
        e_in_ready = 1'b0; e_dop = 1'b0; e_ov = 1'b0; e_busy = 1'b0; e_done = 1'b0;
        e_ctrl = '0;
        if (m_fin) begin
            e_done = 1'b1;
            e_busy = 1'b1;
        end else if (m_active) begin
            e_busy = 1'b1;
            if (m_phase < 0) begin
                e_in_ready = 1'b1;
            end else if (m_phase <= m_k) begin
                e_dop = 1'b1;
                for (int j = 0; j < D; j++)
                    if (j % (1 << m_phase) == 0) e_ctrl[4*j +: 4] = {1'b1, 3'(m_phase - 1)};
            end else if (m_phase <= m_k + LAT) begin
                e_dop = 1'b1;
            end else begin
                e_ov = 1'b1;
            end
        end
    end

    always @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            m_active <= 1'b0; m_fin <= 1'b0; m_phase <= 0; m_k <= 0; m_n <= 0; m_cnt <= 0;
        end else if (m_fin) begin
            m_fin <= 1'b0; m_active <= 1'b0;
        end else if (!m_active) begin
            if (start) begin
                m_k <= (cfg_k > 3'd4) ? 4 : int'(cfg_k);
                m_n <= int'(cfg_count);
                m_cnt <= 0;
                m_active <= 1'b1;
                m_phase <= -1;
                if (cfg_count == '0) m_fin <= 1'b1;
            end
        end else if (e_in_ready) begin
            if (in_valid) m_phase <= 1;
        end else if (e_ov) begin
            if (out_ready) begin
                m_cnt <= m_cnt + 1;
                if (m_cnt + 1 == m_n) m_fin <= 1'b1;
                else m_phase <= -1;
            end
        end else begin
            m_phase <= m_phase + 1;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("in_ready", 64'(in_ready), 64'(e_in_ready));
            chk("doPooling", 64'(doPooling), 64'(e_dop));
            chk("control", control, e_ctrl);
            chk("out_valid", 64'(out_valid), 64'(e_ov));
            chk("busy", 64'(busy), 64'(e_busy));
            chk("done", 64'(done), 64'(e_done));
            chk("ready_valid_excl", 64'(in_ready & out_valid), 64'd0);
            if (done) done_cnt++;
        end
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic kick(input logic [2:0] k, input logic [CW-1:0] n);
        start = 1'b1; cfg_k = k; cfg_count = n;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int d0, hs;
        bit seen, stalled;

        repeat (2) tick();
        RSTN = 1'b1;
        chk_en = 1'b1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_control", control, 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);

        // k=2, one vector
        tick();
        in_valid = 1'b1; out_ready = 1'b1; d0 = done_cnt;
        kick(3'd2, 8'd1);
        chk("t2_in_ready", 64'(in_ready), 64'd1);
        tick();
        chk("t2_s0_lane0", 64'(control[3:0]), 64'h8);
        chk("t2_s0_lane2", 64'(control[11:8]), 64'h8);
        tick();
        chk("t2_s1_lane0", 64'(control[3:0]), 64'h9);
        chk("t2_s1_lane2", 64'(control[11:8]), 64'h0);
        tick();
        chk("t2_wait_dop", 64'(doPooling), 64'd1);
        chk("t2_wait_ov", 64'(out_valid), 64'd0);
        tick();
        chk("t2_ov_at4", 64'(out_valid), 64'd1);
        tick();
        chk("t2_done", 64'(done), 64'd1);
        tick();
        chk("t2_idle_busy", 64'(busy), 64'd0);
        chk("t2_done_once", 64'(done_cnt - d0), 64'd1);

        // k=7 clamps to 4 stages
        kick(3'd7, 8'd1);
        repeat (4) tick();
        chk("t3_s3_lane0", 64'(control[3:0]), 64'hB);
        chk("t3_s3_lane8", 64'(control[35:32]), 64'h0);
        chk("t3_s3_dop", 64'(doPooling), 64'd1);
        tick();
        chk("t3_wait_ctrl", control, 64'd0);
        tick();
        chk("t3_ov", 64'(out_valid), 64'd1);
        repeat (2) tick();

        // empty job
        kick(3'd2, 8'd0);
        chk("t4_done", 64'(done), 64'd1);
        chk("t4_in_ready", 64'(in_ready), 64'd0);
        tick();
        chk("t4_busy_low", 64'(busy), 64'd0);

        // k=0: no reduction stages
        kick(3'd0, 8'd1);
        tick();
        chk("t6_wait_dop", 64'(doPooling), 64'd1);
        chk("t6_wait_ov", 64'(out_valid), 64'd0);
        tick();
        chk("t6_ov_at2", 64'(out_valid), 64'd1);
        repeat (2) tick();

        // three vectors, second output stalled 5 cycles
        kick(3'd1, 8'd3);
        hs = 0; seen = 1'b0; stalled = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            if (done) begin
                seen = 1'b1;
                chk("t5_hs_at_done", 64'(hs), 64'd3);
            end else if (out_valid && hs == 1 && !stalled) begin
                out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    tick();
                    chk("t5_stall_ov", 64'(out_valid), 64'd1);
                    chk("t5_stall_ir", 64'(in_ready), 64'd0);
                    chk("t5_stall_done", 64'(done), 64'd0);
                end
                out_ready = 1'b1;
                stalled = 1'b1;
                hs++;
                tick();
            end else begin
                if (out_valid && out_ready) hs++;
                tick();
            end
        end
        chk("t5_done_seen", 64'(seen), 64'd1);
        chk("t5_stalled", 64'(stalled), 64'd1);
        tick();

        // asynchronous reset in the middle of reduction
        kick(3'd4, 8'd2);
        tick();
        #2 RSTN = 1'b0;
        #1;
        chk("t1_rst_dop", 64'(doPooling), 64'd0);
        chk("t1_rst_ctrl", control, 64'd0);
        chk("t1_rst_busy", 64'(busy), 64'd0);
        chk("t1_rst_ir", 64'(in_ready), 64'd0);
        chk("t1_rst_done", 64'(done), 64'd0);
        tick();
        RSTN = 1'b1;
        tick();
        kick(3'd1, 8'd1);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (done) seen = 1'b1;
            tick();
        end
        chk("t1_job_after_rst", 64'(seen), 64'd1);

        // randomized starts, configs and handshakes
        for (int c = 0; c < 3000; c++) begin
            start     = ($urandom_range(0, 3) == 0);
            cfg_k     = 3'($urandom_range(0, 7));
            cfg_count = CW'($urandom_range(0, 4));
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        start = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        repeat (40) tick();
        chk("final_idle", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
